// File: rtl/alu_op_issue.sv
// Decode-to-execute issue stage: translates ALUOp/funct3/funct7 into the ALU
// Operation code, selects the operands, and buffers the beats in a 2-entry
// valid/ready FIFO with a synchronous flush.
module alu_op_issue #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic                     ALUSrc,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal
);

    localparam int unsigned DEPTH = 2;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

    typedef struct packed {
        logic                     illegal;
        logic [OPCODE_LENGTH-1:0] op;
        logic [DATA_WIDTH-1:0]    src_a;
        logic [DATA_WIDTH-1:0]    src_b;
    } entry_t;

    entry_t     mem [DEPTH];
    entry_t     dec;
    entry_t     head;
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;
    logic       dec_ill;
    logic       f7_zero;

    assign f7_zero = (funct7 == 7'b0000000);

    // Decode the instruction fields into an ALU code and build the entry.
    always_comb begin
        dec_ill = 1'b0;
        dec     = '0;
        dec.op  = OP_ADD;
        case (ALUOp)
            2'b00: dec.op = OP_ADD;
            2'b01: begin
                if (funct3 == 3'b000) dec.op = OP_EQ;
                else                  dec_ill = 1'b1;
            end
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (f7_zero)                    dec.op = OP_ADD;
                        else if (funct7 == 7'b0100000)  dec.op = OP_SUB;
                        else                            dec_ill = 1'b1;
                    end
                    3'b111:  dec.op = OP_AND;
                    3'b110:  dec.op = OP_OR;
                    3'b100:  dec.op = OP_XOR;
                    3'b001: begin
                        if (f7_zero) dec.op = OP_SLL;
                        else         dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000:  dec.op = OP_ADD;
                    3'b111:  dec.op = OP_AND;
                    3'b110:  dec.op = OP_OR;
                    3'b100:  dec.op = OP_XOR;
                    3'b001: begin
                        if (f7_zero) dec.op = OP_SLL;
                        else         dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
        endcase
        if (dec_ill) dec.op = OP_ILL;
        dec.illegal = dec_ill;
        dec.src_a   = rs1_data;
        dec.src_b   = ALUSrc ? imm : rs2_data;
    end

    assign in_ready  = (count < 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // FIFO storage, pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (pop && !push) count <= count - 2'd1;
        end
    end

    // Head entry presented to execute, forced to zero when empty.
    always_comb begin
        head      = out_valid ? mem[rd_ptr] : '0;
        SrcA      = head.src_a;
        SrcB      = head.src_b;
        Operation = head.op;
        illegal   = head.illegal;
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: driver issues directed and random beats,
// a negedge monitor predicts occupancy and checks every presented head entry.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        ALUSrc;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        ill;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t q[$];

    alu_op_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .ALUSrc(ALUSrc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode table: returns {illegal, code}.
    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic [4:0] ill;
        ill = 5'b1_1111;
        if (op == 2'd0) return 5'b0_0010;
        if (op == 2'd1) return (f3 == 3'd0) ? 5'b0_1000 : ill;
        if (f3 == 3'd7) return 5'b0_0000;
        if (f3 == 3'd6) return 5'b0_0011;
        if (f3 == 3'd4) return 5'b0_0001;
        if (f3 == 3'd1) return (f7 == 7'd0) ? 5'b0_1001 : ill;
        if (f3 == 3'd0) begin
            if (op == 2'd3 || f7 == 7'd0) return 5'b0_0010;
            if (f7 == 7'h20)              return 5'b0_0100;
        end
        return ill;
    endfunction

    function automatic exp_t model_beat();
        exp_t e;
        logic [4:0] d;
        d     = ref_dec(ALUOp, funct3, funct7);
        e.ill = d[4];
        e.op  = d[3:0];
        e.a   = rs1_data;
        e.b   = ALUSrc ? imm : rs2_data;
        return e;
    endfunction

    // Monitor: occupancy prediction, head comparison, scoreboard update.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_outputs", {27'd0, illegal, Operation, SrcA}, 64'd0);
            end else begin
                chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
                chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
                if (out_valid && q.size() > 0) begin
                    chk("head_op", {59'd0, illegal, Operation}, {59'd0, q[0].ill, q[0].op});
                    chk("head_src", {SrcA, SrcB}, {q[0].a, q[0].b});
                end else if (!out_valid) begin
                    chk("idle_zero", {SrcA, SrcB}, 64'd0);
                end
                if (flush) q.delete();
                else begin
                    if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                    if (in_valid && in_ready) q.push_back(model_beat());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic src, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] im);
        ALUOp = op; funct3 = f3; funct7 = f7; ALUSrc = src;
        rs1_data = r1; rs2_data = r2; imm = im; in_valid = 1'b1;
    endtask

    // Hold the current beat until accepted, bounded.
    task automatic wait_accept();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            cyc();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic src, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im);
        set_beat(op, f3, f7, src, r1, r2, im);
        wait_accept();
    endtask

    initial begin
        logic [6:0] f7r;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ALUOp = '0; funct3 = '0; funct7 = '0; ALUSrc = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0;
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out", {26'd0, out_valid, illegal, Operation, SrcB}, 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        cyc();

        // SUB, visible the cycle after push
        out_ready = 1'b1;
        send(2'b10, 3'b000, 7'h20, 1'b0, 32'h10, 32'h3, 32'h0);
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_op", {59'd0, illegal, Operation}, 64'h04);
        chk("sub_src", {SrcA, SrcB}, {32'h10, 32'h3});
        cyc();

        // Back-pressure: third beat held off until space frees
        out_ready = 1'b0;
        send(2'b10, 3'b111, 7'h00, 1'b0, 32'h1, 32'h2, 32'h0);
        send(2'b10, 3'b110, 7'h00, 1'b0, 32'h3, 32'h4, 32'h0);
        set_beat(2'b10, 3'b100, 7'h00, 1'b0, 32'h5, 32'h6, 32'h0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cyc(); cyc();
        chk("held_in_ready", 64'(in_ready), 64'd0);
        chk("held_head_op", 64'(Operation), 64'h0);
        out_ready = 1'b1;
        wait_accept();
        repeat (4) cyc();
        chk("drained", 64'(out_valid), 64'd0);

        // I-type immediate, branch EQ, illegal branch
        send(2'b11, 3'b000, 7'h55, 1'b1, 32'd8, 32'h55, 32'hFFFF_FFFC);
        chk("itype_op", 64'(Operation), 64'h2);
        chk("itype_srcb", {SrcA, SrcB}, {32'd8, 32'hFFFF_FFFC});
        send(2'b01, 3'b000, 7'h00, 1'b0, 32'h7, 32'h7, 32'h0);
        chk("beq_op", {59'd0, illegal, Operation}, 64'h08);
        send(2'b01, 3'b001, 7'h00, 1'b0, 32'h7, 32'h8, 32'h0);
        chk("bill_op", {59'd0, illegal, Operation}, 64'h1F);
        cyc();

        // count=1 with simultaneous push and pop
        out_ready = 1'b0;
        send(2'b10, 3'b111, 7'h00, 1'b0, 32'hA, 32'hB, 32'h0);
        set_beat(2'b10, 3'b001, 7'h00, 1'b0, 32'hC, 32'hD, 32'h0);
        out_ready = 1'b1;
        chk("pp_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("pp_valid", 64'(out_valid), 64'd1);
        chk("pp_head", {28'd0, Operation, SrcA}, {28'd0, 4'h9, 32'hC});
        cyc();
        chk("pp_empty", 64'(out_valid), 64'd0);

        // Flush at count=2 drops the same-cycle push
        out_ready = 1'b0;
        send(2'b00, 3'b000, 7'h00, 1'b0, 32'h1, 32'h1, 32'h0);
        send(2'b00, 3'b000, 7'h00, 1'b0, 32'h2, 32'h2, 32'h0);
        set_beat(2'b10, 3'b100, 7'h00, 1'b0, 32'h3, 32'h3, 32'h0);
        flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_state", {out_valid, in_ready}, 64'b01);
        cyc();
        chk("flush_dropped", 64'(out_valid), 64'd0);

        // Async reset between edges at count=2
        send(2'b10, 3'b110, 7'h00, 1'b0, 32'h11, 32'h12, 32'h0);
        send(2'b10, 3'b110, 7'h00, 1'b0, 32'h13, 32'h14, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {26'd0, out_valid, illegal, Operation, SrcA}, 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #3 rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        send(2'b10, 3'b000, 7'h00, 1'b1, 32'h21, 32'h0, 32'h22);
        chk("post_rst_push", {27'd0, out_valid, Operation, SrcB}, {27'd0, 1'b1, 4'h2, 32'h22});
        cyc();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 2))
                0:       f7r = 7'h00;
                1:       f7r = 7'h20;
                default: f7r = 7'($urandom);
            endcase
            set_beat(2'($urandom), 3'($urandom), f7r, 1'($urandom), $urandom, $urandom, $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cyc();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) cyc();
        chk("final_drain", 64'(out_valid), 64'd0);
        chk("final_scoreboard", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Producer side of the ALU operand/opcode interface.
- Takes decoded instruction fields plus register/immediate operands from the decode stage.
- Translates ALUOp/funct3/funct7 into the ALU's 4-bit Operation code, selects SrcA/SrcB, and buffers the result in a 2-entry valid/ready skid FIFO feeding the execute stage.
- Provides back-pressure for execute stalls and a synchronous flush for branch redirects.

Parameters:
- DATA_WIDTH, 32, operand width.
- OPCODE_LENGTH, 4, width of the Operation code driven to the ALU.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decode presents a beat.
- in_ready  output  1  block can accept a beat this cycle.
- ALUOp  input  2  00 load/store/address, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7.
- ALUSrc  input  1  1 = SrcB from imm, 0 = SrcB from rs2_data.
- rs1_data  input  DATA_WIDTH  register operand 1.
- rs2_data  input  DATA_WIDTH  register operand 2.
- imm  input  DATA_WIDTH  sign-extended immediate.
- flush  input  1  synchronous discard of all buffered and incoming beats.
- out_valid  output  1  head entry valid.
- out_ready  input  1  execute consumes head entry.
- SrcA  output  DATA_WIDTH  head entry operand A.
- SrcB  output  DATA_WIDTH  head entry operand B.
- Operation  output  OPCODE_LENGTH  head entry ALU code.
- illegal  output  1  head entry had an undecodable combination.

Behaviour:
- Reset (rst_n low, async): count=0, read/write pointers=0, out_valid=0, in_ready=1, SrcA=SrcB=0, Operation=0000, illegal=0. Storage contents are don't-care but outputs are forced to 0 while out_valid=0.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count<2), registered-derived; never combinationally depends on out_ready.
  - out_valid = (count>0).
- Latency: a pushed beat appears at the outputs the cycle after the push when the FIFO was empty. No combinational path from in_* to out_*.
- Count update: push&!pop → +1; pop&!push → −1; push&pop → unchanged. At count=2, in_ready=0, so push cannot occur. Pointers wrap modulo 2.
- Output data held stable while out_valid=1 and out_ready=0.
- Flush (sync, highest priority over push/pop): count and pointers go to 0 next edge; a same-cycle push is dropped; a same-cycle pop is treated as not having occurred.
- Decode, combinational on input fields, captured on push:
  - ALUOp=00: ADD 0010.
  - ALUOp=01: funct3=000 → EQ 1000; else illegal.
  - ALUOp=10: 000 with funct7=0000000 → ADD 0010; 000 with funct7=0100000 → SUB 0100; 111 → AND 0000; 110 → OR 0011; 100 → XOR 0001; 001 with funct7=0000000 → SLL 1001. Any other funct3/funct7 combination is illegal.
  - ALUOp=11: 000 → ADD; 111 → AND; 110 → OR; 100 → XOR; 001 with funct7=0000000 → SLL. Any other combination is illegal.
  - funct7 is ignored wherever it is not listed above.
  - Illegal beat: Operation=1111, illegal=1; the beat is still queued in order.
- Operand select: SrcA = rs1_data; SrcB = ALUSrc ? imm : rs2_data. Full DATA_WIDTH, no extension.
- Reset asserted mid-operation discards all entries immediately. Outputs return to reset values without waiting for clk.

Test Plan:
- Reset, then push R-type funct3=000 funct7=0100000, rs1=0x10, rs2=0x3, out_ready=1 → next cycle: out_valid=1, Operation=0100, SrcA=0x10, SrcB=0x3, illegal=0.
- out_ready=0, push three beats (AND, OR, XOR) → in_ready drops to 0 after the second push and the third is held off. Raise out_ready → outputs drain in order 0000, 0011, 0001, and the held beat is accepted once space frees.
- Push I-type funct3=000, ALUSrc=1, imm=0xFFFFFFFC, rs1=8 → Operation=0010, SrcB=0xFFFFFFFC. Branch funct3=000 → 1000. Branch funct3=001 → Operation=1111, illegal=1.
- Count=1 with push&pop in the same cycle → count stays 1, the new beat is at the head next cycle, and no bubble appears on out_valid.
- Count=2 with flush=1 and in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, and the incoming beat is not seen.
- Count=2, drop rst_n between clock edges → out_valid=0, Operation=0000, SrcA=0 immediately. After release, the first push emerges one cycle later.
